regfile_wb_arbiter: RTL and testbench

- Write-back arbiter that owns the regfile write port (waddr/wdata/we); sole writer of the register file.
- Merges two result sources: the in-order pipeline MEM/WB result (cannot stall in-cycle, highest priority) and a long-latency unit (e.g. divider) with valid/ready handshake, buffered in a small FIFO.
- Provides pending-write lookups so ID can stall on registers owned by buffered long-latency results, and a starvation stall request to the pipeline.

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: the only writer of the register file.
// Pipeline (A) results always win and are written one cycle later.
// Long-latency (B) results are queued in a small FIFO and drained when A is idle.
// ID can look up pending B writes, and a stall is requested when the FIFO head starves.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_we,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_pend1,
    output logic        q_pend2,
    output logic        stall_req,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_MAX + 1);

    logic [4:0]    addrMem_q [DEPTH];
    logic [31:0]   dataMem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [WW-1:0] waitCnt_q;
    logic [WW-1:0] waitCnt_d;
    logic          we_q;
    logic          we_d;
    logic [4:0]    waddr_q;
    logic [4:0]    waddr_d;
    logic [31:0]   wdata_q;
    logic [31:0]   wdata_d;

    logic aReq;
    logic push;
    logic pop;
    logic empty;
    logic full;

    // Full/empty come from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign b_ready   = !rst && !full;
    assign aReq      = a_we && (a_waddr != 5'd0);
    assign push      = b_valid && b_ready;
    assign pop       = !aReq && !empty;
    assign stall_req = !empty && (waitCnt_q == WW'(STARVE_MAX));

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    // Choose what the regfile port carries next cycle: A first, then the FIFO head, else idle.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (aReq) begin
            we_d    = 1'b1;
            waddr_d = a_waddr;
            wdata_d = a_wdata;
        end else if (pop) begin
            we_d    = (addrMem_q[rptr_q] != 5'd0);
            waddr_d = addrMem_q[rptr_q];
            wdata_d = dataMem_q[rptr_q];
        end
    end

    // Occupancy tracking and the head-of-line wait counter.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        waitCnt_d = waitCnt_q;
        if (empty || pop) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WW'(STARVE_MAX)) begin
            waitCnt_d = waitCnt_q + WW'(1);
        end
    end

    // Pending lookup over every valid FIFO slot, including a head being popped this cycle.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        q_pend1 = 1'b0;
        q_pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((q_addr1 != 5'd0) && (addrMem_q[idx] == q_addr1)) begin
                    q_pend1 = 1'b1;
                end
                if ((q_addr2 != 5'd0) && (addrMem_q[idx] == q_addr2)) begin
                    q_pend2 = 1'b1;
                end
            end
        end
    end

    // FIFO storage; slot contents are only meaningful while counted as valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wptr_q] <= b_waddr;
            dataMem_q[wptr_q] <= b_wdata;
        end
    end

    // Pointers, count, wait counter and the registered regfile port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            waitCnt_q <= '0;
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'd0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q   <= count_d;
            waitCnt_q <= waitCnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the write-back rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_pend1;
    logic        q_pend2;
    logic        stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks  = 0;
    int errors  = 0;
    int stepNum = 0;

    // Reference model state: the FIFO as a plain queue, the head wait time, and the regfile port.
    entry_t      mq[$];
    int          mWait;
    logic        mWe;
    logic [4:0]  mWaddr;
    logic [31:0] mWdata;
    bit          mDataKnown;

    // Free-running clock.
    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_we(a_we),
        .a_waddr(a_waddr),
        .a_wdata(a_wdata),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_waddr(b_waddr),
        .b_wdata(b_wdata),
        .q_addr1(q_addr1),
        .q_addr2(q_addr2),
        .q_pend1(q_pend1),
        .q_pend2(q_pend2),
        .stall_req(stall_req),
        .we(we),
        .waddr(waddr),
        .wdata(wdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL step%0d %s: observed 0x%0h, expected 0x%0h", stepNum, tag, obs, exp);
        end
    endtask

    function automatic bit modelPending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) begin
            if (mq[i].addr == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit modelStall();
        return (mq.size() > 0) && (mWait == STARVE_MAX);
    endfunction

    task automatic modelReset();
        mq.delete();
        mWait      = 0;
        mWe        = 1'b0;
        mWaddr     = 5'd0;
        mWdata     = 32'd0;
        mDataKnown = 1'b1;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, advance model, check registered outputs.
    task automatic applyStimulus(input logic rstV, input logic aWe, input logic [4:0] aAddr,
                                 input logic [31:0] aData, input logic bValid, input logic [4:0] bAddr,
                                 input logic [31:0] bData, input logic [4:0] q1, input logic [4:0] q2);
        bit     expReady;
        bit     aReq;
        bit     popped;
        int     sizeBefore;
        entry_t e;

        rst     = rstV;
        a_we    = aWe;
        a_waddr = aAddr;
        a_wdata = aData;
        b_valid = bValid;
        b_waddr = bAddr;
        b_wdata = bData;
        q_addr1 = q1;
        q_addr2 = q2;
        #1;
        expReady = !rstV && (mq.size() < DEPTH);
        checkOutput("b_ready", {31'd0, b_ready}, {31'd0, expReady});
        checkOutput("q_pend1", {31'd0, q_pend1}, {31'd0, modelPending(q1)});
        checkOutput("q_pend2", {31'd0, q_pend2}, {31'd0, modelPending(q2)});
        checkOutput("stall_req", {31'd0, stall_req}, {31'd0, modelStall()});

        @(posedge clk);
        if (rstV) begin
            modelReset();
        end else begin
            sizeBefore = mq.size();
            aReq       = aWe && (aAddr != 5'd0);
            popped     = !aReq && (sizeBefore > 0);
            if (aReq) begin
                mWe        = 1'b1;
                mWaddr     = aAddr;
                mWdata     = aData;
                mDataKnown = 1'b1;
            end else if (popped) begin
                e      = mq.pop_front();
                mWe    = (e.addr != 5'd0);
                mWaddr = e.addr;
                mWdata = e.data;
                mDataKnown = mWe;
            end else begin
                mWe = 1'b0;
            end
            if (sizeBefore == 0 || popped) mWait = 0;
            else if (mWait < STARVE_MAX) mWait = mWait + 1;
            if (bValid && expReady) begin
                e.addr = bAddr;
                e.data = bData;
                mq.push_back(e);
            end
        end
        #1;
        checkOutput("we", {31'd0, we}, {31'd0, mWe});
        if (mDataKnown) begin
            checkOutput("waddr", {27'd0, waddr}, {27'd0, mWaddr});
            checkOutput("wdata", wdata, mWdata);
        end
        stepNum++;
    endtask

    task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
        end
    endtask

    initial begin
        bit          rndRst;
        bit          rndAWe;
        logic [4:0]  rA;
        logic [4:0]  rB;
        logic [31:0] dA;
        logic [31:0] dB;

        rst     = 1'b1;
        a_we    = 1'b0;
        a_waddr = 5'd0;
        a_wdata = 32'd0;
        b_valid = 1'b0;
        b_waddr = 5'd0;
        b_wdata = 32'd0;
        q_addr1 = 5'd0;
        q_addr2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        $display("[TB] reset and idle");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3, 5'd3, 5'd0);
        idle(2, 5'd1, 5'd2);

        $display("[TB] A-only writes");
        applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(1, 5'd0, 5'd0);

        $display("[TB] B-only write");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD, 5'd7, 5'd0);
        idle(3, 5'd7, 5'd7);

        $display("[TB] A priority while FIFO fills");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(10 + i), 32'hA000 + i, 1'b1, 5'(20 + i), 32'hB000 + i,
                          5'd20, 5'd25);
        end
        idle(6, 5'd20, 5'd23);

        $display("[TB] starvation");
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9999, 5'd9, 5'd0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd2, 32'h100 + i, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        end
        idle(2, 5'd9, 5'd0);

        $display("[TB] reset with entries queued");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd4, 32'h40 + i, 1'b1, 5'(11 + i), 32'hC0 + i, 5'd11, 5'd13);
        end
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd14, 32'hC4, 5'd11, 5'd13);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd13);
        idle(3, 5'd11, 5'd13);

        $display("[TB] pointer wrap with simultaneous push and pop");
        applyStimulus(1'b0, 1'b1, 5'd15, 32'hF0, 1'b1, 5'd3, 32'h3333, 5'd3, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd15, 32'hF1, 1'b1, 5'd0, 32'h0BAD, 5'd3, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd15, 32'hF2, 1'b1, 5'd4, 32'h4444, 5'd4, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd3);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666, 5'd4, 5'd6);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888, 5'd6, 5'd8);
        idle(3, 5'd6, 5'd8);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rndRst = ($urandom_range(0, 49) == 0);
            rndAWe = modelStall() ? 1'b0 : ($urandom_range(0, 2) != 0);
            rA     = 5'($urandom_range(0, 7));
            rB     = 5'($urandom_range(0, 7));
            dA     = $urandom;
            dB     = $urandom;
            applyStimulus(rndRst, rndAWe, rA, dA, ($urandom_range(0, 1) == 1), rB, dB,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(8, 5'd1, 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
